arch_map_table: RTL and testbench
=================================

Name: arch_map_table

Overview:
- Architectural (retirement) map table for the N-way out-of-order core. Sits directly upstream of the physical-register freelist.
- On each retiring instruction with a destination, it installs the committed physical tag. It then returns the previously committed tag to the freelist through a registered N-lane free port.
- It also exposes the full committed map, which the rename map table uses for mispredict recovery.

Parameters:
- N, `N, retire width (lanes); lane 0 is oldest.
- ARCH_REGS, 32, number of architectural registers.
- PHYS_REGS, 64, number of physical registers; PHYS_TAG width = $clog2(PHYS_REGS).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- retire_valid  in  N  lane i retires an instruction that writes a destination register.
- retire_arch  in  N x $clog2(ARCH_REGS)  architectural destination per lane.
- retire_phys  in  N x PHYS_TAG  physical tag being committed per lane.
- free_valid  out  N  registered; drives freelist RetireEN.
- free_tag  out  N x PHYS_TAG  registered; drives freelist RetireReg.
- arch_map_out  out  ARCH_REGS x PHYS_TAG  current committed mapping, driven directly from the state registers.

Behaviour:
- State: map[ARCH_REGS] of PHYS_TAG, plus registered free_valid/free_tag.
- Reset (synchronous, has priority over all retire inputs in the same cycle):
  - map[i] = i for all i.
  - free_valid = 0, free_tag = 0.
  - The freelist therefore owns tags ARCH_REGS..PHYS_REGS-1 after reset.
  - Tag 0 is permanently bound to x0 and is never freed.
- Lane qualification: lane i is effective when retire_valid[i]=1 and retire_arch[i]!=0. Non-effective lanes:
  - leave map unchanged;
  - produce free_valid[i]=0 next cycle;
  - set free_tag[i]=0.
- Lanes need not be contiguous. Any valid pattern is legal, processed in lane-index (program) order.
- Old-tag resolution for effective lane i:
  - old_i = retire_phys[j], where j is the highest-indexed effective lane j<i with retire_arch[j]==retire_arch[i];
  - otherwise old_i = map[retire_arch[i]] (value before this edge).
- Map update: map[a] <= retire_phys of the youngest (highest-index) effective lane targeting a. Untouched entries hold.
- Free port, 1-cycle latency: at the posedge where lane i is effective, free_valid[i] <= 1 and free_tag[i] <= old_i. Otherwise free_valid[i] <= 0.
- Outputs are held one cycle only; there is no backpressure. The freelist must accept every asserted lane.
- arch_map_out reflects updates one cycle after the retiring edge, with no bypass of same-cycle retires.
- Invariant: free_tag on a valid lane is never 0, never X, and unique across lanes within a cycle.
- Illegal input: effective lane with retire_phys==0, or retire_phys equal to a tag currently in map. The simulation assertion fires with "@@@ Failed". RTL behaviour is unspecified.
- Reset asserted mid-stream: pending free outputs are discarded (cleared at that edge), and the map reverts to identity.

Test Plan:
- Reset 2 cycles -> arch_map_out[i]==i for all i; free_valid==0.
- Lane0 retire x5->40 -> next cycle free_valid=0..01, free_tag[0]=5; following cycle arch_map_out[5]=40; free_valid returns to 0.
- Same-cycle chain (N>=3): lanes0/1/2 retire x7->40, x7->41, x7->42 -> free_tag = {7, 40, 41}, all valid; map[7]=42; no duplicate tags.
- x0 filter: lane1 retire_arch=0 phys=50, lane0 x3->33 -> free_valid[1]=0, free_valid[0]=1 tag 3; map[0] stays 0.
- Back-to-back: cycle A x3->33, cycle B x3->34 -> frees 3 at A+1, then 33 at B+1; map[3]=34.
- Reset with retire_valid=all-ones on the same edge -> no free output next cycle; map identity.

Source files
------------

// File: rtl/arch_map_table.sv
// Architectural (retirement) map table: installs committed physical tags and
// returns each displaced tag to the freelist through a registered N-lane port.
module arch_map_table #(
  parameter int unsigned N         = 4,
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 64
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [N-1:0]                               retire_valid,
  input  logic [N-1:0][$clog2(ARCH_REGS)-1:0]        retire_arch,
  input  logic [N-1:0][$clog2(PHYS_REGS)-1:0]        retire_phys,
  output logic [N-1:0]                               free_valid,
  output logic [N-1:0][$clog2(PHYS_REGS)-1:0]        free_tag,
  output logic [ARCH_REGS-1:0][$clog2(PHYS_REGS)-1:0] arch_map_out
);

  localparam int unsigned AW = $clog2(ARCH_REGS);
  localparam int unsigned TW = $clog2(PHYS_REGS);

  logic [ARCH_REGS-1:0][TW-1:0] map;
  logic [ARCH_REGS-1:0][TW-1:0] mapNext;
  logic [N-1:0]                 effective;
  logic [N-1:0][TW-1:0]         oldTag;

  // x0 is hard-wired to tag 0, so retires to it are dropped entirely
  always_comb begin
    effective = '0;
    for (int unsigned i = 0; i < N; i++) begin
      effective[i] = retire_valid[i] && (retire_arch[i] != AW'(0));
    end
  end

  // Old tag comes from the youngest older lane to the same register, else the map
  always_comb begin
    oldTag = '0;
    for (int unsigned i = 0; i < N; i++) begin
      oldTag[i] = map[retire_arch[i]];
      for (int unsigned j = 0; j < i; j++) begin
        if (effective[j] && (retire_arch[j] == retire_arch[i])) begin
          oldTag[i] = retire_phys[j];
        end
      end
    end
  end

  // Lanes applied in program order so the youngest writer wins
  always_comb begin
    mapNext = map;
    for (int unsigned i = 0; i < N; i++) begin
      if (effective[i]) begin
        mapNext[retire_arch[i]] = retire_phys[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        map[i] <= TW'(i);
      end
      free_valid <= '0;
      free_tag   <= '0;
    end else begin
      map        <= mapNext;
      free_valid <= effective;
      for (int unsigned i = 0; i < N; i++) begin
        free_tag[i] <= effective[i] ? oldTag[i] : TW'(0);
      end
    end
  end

  assign arch_map_out = map;

  // Committing tag 0 or a tag still mapped would corrupt the freelist
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (effective[i]) begin
          assert (retire_phys[i] != TW'(0))
            else $error("@@@ Failed: lane %0d commits tag 0", i);
          for (int unsigned a = 0; a < ARCH_REGS; a++) begin
            assert (map[a] != retire_phys[i])
              else $error("@@@ Failed: lane %0d commits tag %0d already mapped to x%0d",
                          i, retire_phys[i], a);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_arch_map_table.sv
// Directed, table-driven bench for arch_map_table with hand-computed expectations.
module tb_arch_map_table;

  localparam int unsigned N  = 4;
  localparam int unsigned AR = 32;
  localparam int unsigned PR = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned TW = 6;
  localparam int unsigned NV = 8;

  logic                    clock;
  logic                    reset;
  logic [N-1:0]            retire_valid;
  logic [N-1:0][AW-1:0]    retire_arch;
  logic [N-1:0][TW-1:0]    retire_phys;
  logic [N-1:0]            free_valid;
  logic [N-1:0][TW-1:0]    free_tag;
  logic [AR-1:0][TW-1:0]   arch_map_out;

  arch_map_table #(.N(N), .ARCH_REGS(AR), .PHYS_REGS(PR)) dut (
    .clock        (clock),
    .reset        (reset),
    .retire_valid (retire_valid),
    .retire_arch  (retire_arch),
    .retire_phys  (retire_phys),
    .free_valid   (free_valid),
    .free_tag     (free_tag),
    .arch_map_out (arch_map_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0]         valid;
    logic [N-1:0][AW-1:0] arch;
    logic [N-1:0][TW-1:0] phys;
    logic [N-1:0]         expValid;
    logic [N-1:0][TW-1:0] expTag;
    logic [AW-1:0]        chkArch;
    logic [TW-1:0]        chkPhys;
  } vec_t;

  vec_t vec [NV];
  int   nChecks = 0;
  int   nFail   = 0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    retire_valid = '0;
    retire_arch  = '0;
    retire_phys  = '0;
  endtask

  task automatic setLane(input int v, input int lane, input bit vld, input int arch,
                         input int phys, input bit ev, input int et);
    vec[v].valid[lane]    = vld;
    vec[v].arch[lane]     = AW'(arch);
    vec[v].phys[lane]     = TW'(phys);
    vec[v].expValid[lane] = ev;
    vec[v].expTag[lane]   = TW'(et);
  endtask

  task automatic checkIdentity(input string name);
    for (int a = 0; a < int'(AR); a++) begin
      check($sformatf("%s map[%0d]", name, a), int'(arch_map_out[a]), a);
    end
  endtask

  initial begin
    for (int v = 0; v < int'(NV); v++) begin
      for (int l = 0; l < int'(N); l++) setLane(v, l, 1'b0, 0, 0, 1'b0, 0);
    end
    // same-cycle chain on x7
    setLane(0, 0, 1, 7, 40, 1, 7);
    setLane(0, 1, 1, 7, 41, 1, 40);
    setLane(0, 2, 1, 7, 42, 1, 41);
    vec[0].chkArch = 7;  vec[0].chkPhys = 42;
    // x0 filter on lane1
    setLane(1, 0, 1, 3, 33, 1, 3);
    setLane(1, 1, 1, 0, 50, 0, 0);
    vec[1].chkArch = 0;  vec[1].chkPhys = 0;
    // back-to-back on x3
    setLane(2, 0, 1, 3, 34, 1, 33);
    vec[2].chkArch = 3;  vec[2].chkPhys = 34;
    // non-contiguous lanes
    setLane(3, 1, 1, 10, 51, 1, 10);
    setLane(3, 3, 1, 9, 50, 1, 9);
    vec[3].chkArch = 9;  vec[3].chkPhys = 50;
    // interleaved chains on x9 and x4
    setLane(4, 0, 1, 9, 52, 1, 50);
    setLane(4, 1, 1, 4, 53, 1, 4);
    setLane(4, 2, 1, 9, 54, 1, 52);
    setLane(4, 3, 1, 4, 55, 1, 53);
    vec[4].chkArch = 9;  vec[4].chkPhys = 54;
    // invalid lanes with live-looking payload
    for (int l = 0; l < int'(N); l++) setLane(5, l, 0, 4, 60 + l, 0, 0);
    vec[5].chkArch = 4;  vec[5].chkPhys = 55;
    // all valid, all x0
    for (int l = 0; l < int'(N); l++) setLane(6, l, 1, 0, 56 + l, 0, 0);
    vec[6].chkArch = 0;  vec[6].chkPhys = 0;
    // top register, top tag
    setLane(7, 2, 1, 31, 63, 1, 31);
    vec[7].chkArch = 31; vec[7].chkPhys = 63;

    clearInputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkIdentity("reset");
    check("reset free_valid", int'(free_valid), 0);

    // single retire x5 -> 40
    retire_valid[0] = 1'b1; retire_arch[0] = 5; retire_phys[0] = 40;
    tick();
    clearInputs();
    check("single free_valid", int'(free_valid), 1);
    check("single free_tag0", int'(free_tag[0]), 5);
    check("single map[5]", int'(arch_map_out[5]), 40);
    tick();
    check("single free_valid drop", int'(free_valid), 0);
    check("single map[5] hold", int'(arch_map_out[5]), 40);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkIdentity("rereset");

    for (int v = 0; v < int'(NV); v++) begin
      retire_valid = vec[v].valid;
      retire_arch  = vec[v].arch;
      retire_phys  = vec[v].phys;
      tick();
      check($sformatf("vec%0d free_valid", v), int'(free_valid), int'(vec[v].expValid));
      for (int l = 0; l < int'(N); l++) begin
        check($sformatf("vec%0d free_tag%0d", v, l), int'(free_tag[l]), int'(vec[v].expTag[l]));
      end
      check($sformatf("vec%0d map[%0d]", v, vec[v].chkArch),
            int'(arch_map_out[vec[v].chkArch]), int'(vec[v].chkPhys));
    end
    clearInputs();
    tick();
    check("idle free_valid", int'(free_valid), 0);
    check("idle map[3]", int'(arch_map_out[3]), 34);
    check("idle map[7]", int'(arch_map_out[7]), 42);
    check("idle map[4]", int'(arch_map_out[4]), 55);

    // retire then reset next edge with all lanes valid: pending free is discarded
    retire_valid[0] = 1'b1; retire_arch[0] = 6; retire_phys[0] = 45;
    tick();
    check("pre-reset free_valid", int'(free_valid), 1);
    check("pre-reset free_tag0", int'(free_tag[0]), 6);
    reset = 1'b1;
    retire_valid = '1;
    for (int l = 0; l < int'(N); l++) begin
      retire_arch[l] = AW'(l + 1);
      retire_phys[l] = TW'(20 + l);
    end
    tick();
    reset = 1'b0;
    clearInputs();
    check("reset-retire free_valid", int'(free_valid), 0);
    check("reset-retire free_tag", int'(free_tag), 0);
    checkIdentity("reset-retire");
    tick();
    check("post-reset free_valid", int'(free_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
